// File: rtl/opo_lock_servo.sv
// OPO lock servo: scans the piezo DAC until the lock-in error enters the window, then runs a pipelined PI loop.
// Optional macro OPO_SERVO_TRIANGLE_EN selects a bidirectional triangle scan; default build uses an upward sawtooth.
module opo_lock_servo #(
  parameter int SHIFT   = 12,
  parameter int HOLD    = 64,
  parameter int DAC_MID = 8192
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic signed [15:0] err_i,
  input  logic               err_valid_i,
  input  logic               enable_i,
  input  logic [15:0]        kp_i,
  input  logic [15:0]        ki_i,
  input  logic [13:0]        scan_step_i,
  input  logic [15:0]        thresh_i,
  output logic [13:0]        dac_o,
  output logic [1:0]         state_o,
  output logic               locked_o,
  output logic [7:0]         relock_cnt_o
);

  localparam int                 CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0]      HOLD_C = CW'(HOLD);
  localparam logic [13:0]        MID_C  = 14'(DAC_MID);
  localparam logic signed [31:0] MID32  = 32'(DAC_MID);
  localparam logic signed [32:0] MID33  = 33'(DAC_MID);
  localparam logic signed [34:0] MID35  = 35'(DAC_MID);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    ACQUIRE = 2'd2,
    LOCK    = 2'd3
  } state_e;

  state_e             state_q;
  logic [13:0]        dac_q;
  logic               locked_q;
  logic [7:0]         relock_q;
  logic signed [31:0] integ_q;
  logic [CW-1:0]      holdCnt_q;
  logic [CW-1:0]      bigCnt_q;
  logic [CW-1:0]      satCnt_q;
  logic               stage1Valid_q;
  logic               bigErr_q;
  logic signed [32:0] pTerm_q;
  logic signed [32:0] iInc_q;
`ifdef OPO_SERVO_TRIANGLE_EN
  logic               dirUp_q;
  logic               dirUp_d;
  logic [14:0]        upSum;
`endif

  logic signed [16:0] errExt;
  logic [16:0]        errMag;
  logic               inWin;
  logic               bigErr;
  logic signed [32:0] kpProd;
  logic signed [32:0] kiProd;
  logic [13:0]        scanDac_d;
  logic signed [33:0] integSum;
  logic signed [31:0] integNext_d;
  logic signed [34:0] dacSum;
  logic [13:0]        dacLock_d;
  logic signed [32:0] midInteg;
  logic               integOut;
  logic               lossA;
  logic               lossB;
  logic signed [31:0] entryInteg;

  // 17-bit magnitude so that -32768 maps to 32768 without wrapping
  always_comb begin
    errExt = {err_i[15], err_i};
    errMag = errExt[16] ? -errExt : errExt;
    inWin  = errMag < {1'b0, thresh_i};
    bigErr = {1'b0, errMag} >= {thresh_i, 2'b00};
    kpProd = $signed({17'd0, kp_i}) * $signed({{17{err_i[15]}}, err_i});
    kiProd = $signed({17'd0, ki_i}) * $signed({{17{err_i[15]}}, err_i});
  end

  always_comb begin
`ifdef OPO_SERVO_TRIANGLE_EN
    upSum     = {1'b0, dac_q} + {1'b0, scan_step_i};
    scanDac_d = dac_q;
    dirUp_d   = dirUp_q;
    if (dirUp_q) begin
      if (upSum > 15'd16383) begin
        scanDac_d = 14'h3FFF;
        dirUp_d   = 1'b0;
      end else begin
        scanDac_d = upSum[13:0];
      end
    end else if (scan_step_i >= dac_q) begin
      scanDac_d = 14'd0;
      dirUp_d   = 1'b1;
    end else begin
      scanDac_d = dac_q - scan_step_i;
    end
`else
    scanDac_d = dac_q + scan_step_i;
`endif
  end

  // Second pipeline stage: integrate, then form the saturated actuator word
  always_comb begin
    integSum = $signed({{2{integ_q[31]}}, integ_q}) + $signed({iInc_q[32], iInc_q});
    if (integSum[33:31] == 3'b000 || integSum[33:31] == 3'b111) begin
      integNext_d = integSum[31:0];
    end else begin
      integNext_d = integSum[33] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
    dacSum = MID35 + $signed({{2{pTerm_q[32]}}, pTerm_q})
                   + $signed({{3{integNext_d[31]}}, integNext_d});
    if (dacSum[34]) begin
      dacLock_d = 14'd0;
    end else if (dacSum > 35'sd16383) begin
      dacLock_d = 14'h3FFF;
    end else begin
      dacLock_d = dacSum[13:0];
    end
    midInteg   = $signed({integNext_d[31], integNext_d}) + MID33;
    integOut   = midInteg[32] || (midInteg > 33'sd16383);
    lossA      = bigErr_q && (bigCnt_q + CW'(1) == HOLD_C);
    lossB      = integOut && (satCnt_q + CW'(1) == HOLD_C);
    entryInteg = $signed({18'd0, dac_q}) - MID32;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      dac_q         <= MID_C;
      locked_q      <= 1'b0;
      relock_q      <= 8'd0;
      integ_q       <= 32'sd0;
      holdCnt_q     <= '0;
      bigCnt_q      <= '0;
      satCnt_q      <= '0;
      stage1Valid_q <= 1'b0;
      bigErr_q      <= 1'b0;
      pTerm_q       <= 33'sd0;
      iInc_q        <= 33'sd0;
`ifdef OPO_SERVO_TRIANGLE_EN
      dirUp_q       <= 1'b1;
`endif
    end else if (!enable_i) begin
      state_q       <= IDLE;
      locked_q      <= 1'b0;
      integ_q       <= 32'sd0;
      holdCnt_q     <= '0;
      bigCnt_q      <= '0;
      satCnt_q      <= '0;
      stage1Valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= SCAN;
          dac_q     <= MID_C;
          holdCnt_q <= '0;
        end
        SCAN: begin
          if (err_valid_i) begin
            dac_q <= scanDac_d;
`ifdef OPO_SERVO_TRIANGLE_EN
            dirUp_q <= dirUp_d;
`endif
            if (inWin) begin
              state_q   <= ACQUIRE;
              holdCnt_q <= CW'(1);
            end
          end
        end
        ACQUIRE: begin
          if (err_valid_i) begin
            if (!inWin) begin
              state_q   <= SCAN;
              holdCnt_q <= '0;
            end else if (holdCnt_q + CW'(1) == HOLD_C) begin
              state_q       <= LOCK;
              locked_q      <= 1'b1;
              integ_q       <= entryInteg;
              holdCnt_q     <= '0;
              bigCnt_q      <= '0;
              satCnt_q      <= '0;
              stage1Valid_q <= 1'b0;
            end else begin
              holdCnt_q <= holdCnt_q + CW'(1);
            end
          end
        end
        LOCK: begin
          stage1Valid_q <= err_valid_i;
          if (err_valid_i) begin
            pTerm_q  <= kpProd >>> SHIFT;
            iInc_q   <= kiProd >>> SHIFT;
            bigErr_q <= bigErr;
          end
          if (stage1Valid_q) begin
            if (lossA || lossB) begin
              state_q  <= SCAN;
              locked_q <= 1'b0;
              integ_q  <= 32'sd0;
              dac_q    <= MID_C;
              bigCnt_q <= '0;
              satCnt_q <= '0;
              relock_q <= (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
            end else begin
              integ_q  <= integNext_d;
              dac_q    <= dacLock_d;
              bigCnt_q <= bigErr_q ? bigCnt_q + CW'(1) : '0;
              satCnt_q <= integOut ? satCnt_q + CW'(1) : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dac_o        = dac_q;
  assign state_o      = state_q;
  assign locked_o     = locked_q;
  assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_opo_lock_servo.sv
// Self-checking bench for opo_lock_servo against a sample-level behavioural model.
// Honors OPO_SERVO_TRIANGLE_EN so the same bench covers both scan builds.
module tb_opo_lock_servo;

  logic               clk = 1'b0;
  logic               rstN;
  logic signed [15:0] errIn;
  logic               errValid;
  logic               enable;
  logic [15:0]        kp;
  logic [15:0]        ki;
  logic [13:0]        scanStep;
  logic [15:0]        thresh;
  logic [13:0]        dac;
  logic [1:0]         state;
  logic               locked;
  logic [7:0]         relockCnt;

  int nChecks = 0;
  int nBad    = 0;

  int     mState;
  int     mDac;
  int     mHold;
  int     mBig;
  int     mSat;
  int     mRelock;
  longint mInteg;
  bit     mDirUp;

  always #5 clk = ~clk;

  opo_lock_servo dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .err_i        (errIn),
    .err_valid_i  (errValid),
    .enable_i     (enable),
    .kp_i         (kp),
    .ki_i         (ki),
    .scan_step_i  (scanStep),
    .thresh_i     (thresh),
    .dac_o        (dac),
    .state_o      (state),
    .locked_o     (locked),
    .relock_cnt_o (relockCnt)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    nChecks++;
    if (obs != exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".dac"}, dac, mDac);
    checkOutput({tag, ".state"}, state, mState);
    checkOutput({tag, ".locked"}, locked, (mState == 3) ? 1 : 0);
    checkOutput({tag, ".relock"}, relockCnt, mRelock);
  endtask

  function automatic void modelReset();
    mState  = 0;
    mDac    = 8192;
    mHold   = 0;
    mBig    = 0;
    mSat    = 0;
    mRelock = 0;
    mInteg  = 0;
    mDirUp  = 1'b1;
  endfunction

  // One accepted error sample, applied with the servo rules in plain integer arithmetic
  function automatic void modelStep(input int e);
    int     mag;
    int     th;
    int     st;
    bit     win;
    bit     big;
    longint p;
    longint inc;
    longint v;
    longint midInteg;
    mag = (e < 0) ? -e : e;
    th  = int'(thresh);
    st  = int'(scanStep);
    win = mag < th;
    big = mag >= 4 * th;
    case (mState)
      1: begin
`ifdef OPO_SERVO_TRIANGLE_EN
        if (mDirUp) begin
          if (mDac + st > 16383) begin
            mDac   = 16383;
            mDirUp = 1'b0;
          end else begin
            mDac = mDac + st;
          end
        end else begin
          if (mDac - st <= 0) begin
            mDac   = 0;
            mDirUp = 1'b1;
          end else begin
            mDac = mDac - st;
          end
        end
`else
        mDac = (mDac + st) % 16384;
`endif
        if (win) begin
          mState = 2;
          mHold  = 1;
        end
      end
      2: begin
        if (win) begin
          mHold++;
          if (mHold == 64) begin
            mState = 3;
            mInteg = mDac - 8192;
            mBig   = 0;
            mSat   = 0;
          end
        end else begin
          mState = 1;
          mHold  = 0;
        end
      end
      3: begin
        p   = (longint'(kp) * e) >>> 12;
        inc = (longint'(ki) * e) >>> 12;
        mInteg = mInteg + inc;
        if (mInteg > 64'sd2147483647) mInteg = 64'sd2147483647;
        if (mInteg < -64'sd2147483648) mInteg = -64'sd2147483648;
        v = 8192 + p + mInteg;
        midInteg = 8192 + mInteg;
        mBig = big ? mBig + 1 : 0;
        mSat = (midInteg < 0 || midInteg > 16383) ? mSat + 1 : 0;
        if (mBig >= 64 || mSat >= 64) begin
          mState = 1;
          mInteg = 0;
          mDac   = 8192;
          mBig   = 0;
          mSat   = 0;
          mHold  = 0;
          if (mRelock < 255) mRelock++;
        end else begin
          mDac = (v < 0) ? 0 : (v > 16383) ? 16383 : int'(v);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic applyStimulus(input int e);
    errIn    = 16'(e);
    errValid = 1'b1;
    @(posedge clk); #1;
    errValid = 1'b0;
    modelStep(e);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic applyBurst(input int e);
    errIn    = 16'(e);
    errValid = 1'b1;
    @(posedge clk); #1;
    modelStep(e);
  endtask

  task automatic endBurst();
    errValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic dropEnable();
    enable = 1'b0;
    @(posedge clk); #1;
    mState = 0;
    mInteg = 0;
    mHold  = 0;
    mBig   = 0;
    mSat   = 0;
  endtask

  task automatic raiseEnable();
    enable = 1'b1;
    @(posedge clk); #1;
    mState = 1;
    mDac   = 8192;
    mHold  = 0;
  endtask

  initial begin
    int preRelock;
    int preDac;
    int th;
    int e;
    rstN     = 1'b0;
    enable   = 1'b1;
    errValid = 1'b0;
    errIn    = '0;
    kp       = '0;
    ki       = '0;
    thresh   = 16'd10;
    scanStep = '0;
    modelReset();

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      errValid = ~errValid;
    end
    compareAll("rst");
    errValid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    mState = 1;
    checkOutput("rst.firstClk", state, 1);

    // Scan toward the top of the range, then cross it with a step of 100
    scanStep = 14'd2027;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1000);
      compareAll("scan");
    end
    checkOutput("scan.at16300", dac, 16300);
    scanStep = 14'd100;
    applyStimulus(1000);
    compareAll("scanEdge");
`ifdef OPO_SERVO_TRIANGLE_EN
    checkOutput("scan.clampTop", dac, 16383);
    applyStimulus(1000);
    checkOutput("scan.turnDown", dac, 16283);
`else
    checkOutput("scan.wrap", dac, 16);
`endif

    applyStimulus(5);
    checkOutput("acq.enter", state, 2);
    for (int i = 2; i < 30; i++) begin
      applyStimulus(5);
      compareAll("acq");
    end
    applyStimulus(50);
    checkOutput("acq.abort", state, 1);
    compareAll("acqAbort");

    // Zero scan step keeps the actuator at mid-scale so lock starts with integ=0
    dropEnable();
    raiseEnable();
    compareAll("reEnable");
    scanStep = '0;
    applyStimulus(5);
    checkOutput("acq.enter2", state, 2);
    for (int i = 2; i < 64; i++) begin
      applyStimulus(5);
      compareAll("acq2");
    end
    checkOutput("acq.sample63", state, 2);
    applyStimulus(5);
    checkOutput("lock.state", state, 3);
    checkOutput("lock.locked", locked, 1);

    kp       = 16'd4096;
    ki       = 16'd0;
    errIn    = 16'sd100;
    errValid = 1'b1;
    @(posedge clk); #1;
    errValid = 1'b0;
    checkOutput("lock.lat1", dac, 8192);
    @(posedge clk); #1;
    checkOutput("lock.lat2", dac, 8292);
    modelStep(100);
    @(posedge clk); #1;
    compareAll("lockP");
    kp = 16'hFFFF;
    applyStimulus(-32768);
    checkOutput("lock.satLow", dac, 0);
    applyStimulus(32767);
    checkOutput("lock.satHigh", dac, 16383);
    applyStimulus(5);
    compareAll("lockSmall");

    preRelock = mRelock;
    kp = 16'd4096;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(40);
      compareAll("lossA");
    end
    checkOutput("lossA.state", state, 1);
    checkOutput("lossA.dac", dac, 8192);
    checkOutput("lossA.relock", relockCnt, preRelock + 1);

    // Integrator pinned outside the actuator range
    preRelock = mRelock;
    thresh = 16'hFFFF;
    kp     = 16'd0;
    ki     = 16'hFFFF;
    for (int i = 0; i < 128; i++) begin
      applyStimulus(30000);
      compareAll("lossB");
    end
    checkOutput("lossB.state", state, 1);
    checkOutput("lossB.relock", relockCnt, preRelock + 1);

    for (int seg = 0; seg < 6; seg++) begin
      kp       = 16'($urandom_range(0, 65535));
      ki       = 16'($urandom_range(0, 4095));
      th       = int'($urandom_range(1, 3000));
      thresh   = 16'(th);
      scanStep = 14'($urandom_range(0, 16383));
      for (int i = 0; i < 80; i++) begin
        if (seg % 2 == 0) e = int'($urandom_range(0, 2 * th - 2)) - (th - 1);
        else              e = int'($urandom_range(0, 65535)) - 32768;
        applyStimulus(e);
        compareAll("rand");
        if ($urandom_range(0, 99) == 0) begin
          dropEnable();
          compareAll("randDrop");
          raiseEnable();
        end
      end
    end

    // Enable falls on the very clock where loss-of-lock would have fired
    dropEnable();
    raiseEnable();
    thresh   = 16'd10;
    scanStep = '0;
    kp       = 16'd4096;
    ki       = 16'd0;
    for (int i = 0; i < 64; i++) applyStimulus(5);
    checkOutput("en.locked", state, 3);
    for (int i = 0; i < 63; i++) begin
      applyStimulus(40);
      compareAll("enLoss");
    end
    preRelock = mRelock;
    preDac    = mDac;
    errIn     = 16'sd40;
    errValid  = 1'b1;
    @(posedge clk); #1;
    errValid = 1'b0;
    enable   = 1'b0;
    @(posedge clk); #1;
    checkOutput("en.state", state, 0);
    checkOutput("en.relock", relockCnt, preRelock);
    checkOutput("en.dac", dac, preDac);
    checkOutput("en.lockedLow", locked, 0);
    mState = 0;
    mInteg = 0;
    mHold  = 0;
    mBig   = 0;
    mSat   = 0;
    raiseEnable();

    kp = '0;
    ki = '0;
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 64; i++) applyBurst(5);
      for (int i = 0; i < 64; i++) applyBurst(40);
      endBurst();
      if (r == 0) compareAll("relockFirst");
    end
    compareAll("relockEnd");
    checkOutput("relock.sat", relockCnt, 255);

    // Asynchronous reset in the middle of a clock period while locked
    for (int i = 0; i < 64; i++) applyBurst(5);
    endBurst();
    kp = 16'd4096;
    applyStimulus(100);
    compareAll("preReset");
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("arst.state", state, 0);
    checkOutput("arst.dac", dac, 8192);
    checkOutput("arst.locked", locked, 0);
    checkOutput("arst.relock", relockCnt, 0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
